// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD AHB register block: register word offsets,
// field bit positions and the panel-reset sequencer state encoding.
package lcd_pkg;

  // Offsets are word indices, i.e. HADDR[4:2]
  localparam logic [2:0] LCD_CTRL_OFS   = 3'd0;
  localparam logic [2:0] LCD_CMD_OFS    = 3'd1;
  localparam logic [2:0] LCD_SC_OFS     = 3'd2;
  localparam logic [2:0] LCD_EC_OFS     = 3'd3;
  localparam logic [2:0] LCD_SP_OFS     = 3'd4;
  localparam logic [2:0] LCD_EP_OFS     = 3'd5;
  localparam logic [2:0] LCD_STATUS_OFS = 3'd6;

  localparam int LCD_NUM_WIN = 4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_RST_BIT   = 1;
  localparam int CMD_INI_BIT    = 0;
  localparam int CMD_COLOR_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_INI_BIT   = 1;
  localparam int STAT_COLOR_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RST_LOW,
    RST_WAIT
  } seq_state_t;

endpackage

// File: rtl/lcd_ahb_regs_if.sv
// AHB-Lite signal bundle between the Cortex-M0 bus fabric and the LCD register slave.
interface lcd_ahb_regs_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/lcd_rst_seq.sv
// Panel reset sequencer: holds lcd_rstn low for RST_LOW_CYCLES, then waits
// RST_WAIT_CYCLES for the panel to settle. Runs after system reset and on start.
module lcd_rst_seq
  import lcd_pkg::*;
#(
  parameter int RST_LOW_CYCLES  = 50000,
  parameter int RST_WAIT_CYCLES = 6000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic lcd_rstn
);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lcd_rstn_reg;

  // lcd_rstn is registered from the next state so the pin never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RST_LOW;
      cnt_reg      <= '0;
      lcd_rstn_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      lcd_rstn_reg <= (state_next != RST_LOW);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RST_LOW: begin
        if (cnt_reg == LOW_LAST) begin
          state_next = RST_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
    // A restart request wins over normal progress in any state
    if (start) begin
      state_next = RST_LOW;
      cnt_next   = '0;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign lcd_rstn = lcd_rstn_reg;

endmodule

// File: rtl/lcd_ahb_regs.sv
// AHB-Lite slave exposing LCD control, command and window registers; drives the
// LCD core enable, one-shot command strobes, window bounds and panel reset.
module lcd_ahb_regs
  import lcd_pkg::*;
#(
  parameter int RST_LOW_CYCLES  = 50000,
  parameter int RST_WAIT_CYCLES = 6000000,
  parameter int CNT_W           = 24
) (
  input  logic           clk,
  input  logic           rst,
  lcd_ahb_regs_if.slave  bus,
  output logic           en,
  output logic           ini_en,
  output logic           color_en,
  output logic [31:0]    set_sc,
  output logic [31:0]    set_ec,
  output logic [31:0]    set_sp,
  output logic [31:0]    set_ep,
  output logic           lcd_rstn
);

  logic        accept;
  logic        valid_reg;
  logic        write_reg;
  logic [2:0]  addr_reg;
  logic        wr_en, rd_en, wr_ctrl, wr_cmd, seq_start, busy;
  logic        en_reg;
  logic        ini_pend_reg, ini_pend_next;
  logic        color_pend_reg, color_pend_next;
  logic [31:0] win_q [LCD_NUM_WIN];
  logic [31:0] rdata;
  logic        unused_bus_bits;

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
    end else begin
      valid_reg <= accept;
      if (accept) begin
        write_reg <= bus.HWRITE;
        addr_reg  <= bus.HADDR[4:2];
      end
    end
  end

  assign wr_en     = valid_reg & write_reg;
  assign rd_en     = valid_reg & ~write_reg;
  assign wr_ctrl   = wr_en & (addr_reg == LCD_CTRL_OFS);
  assign wr_cmd    = wr_en & (addr_reg == LCD_CMD_OFS);
  assign seq_start = wr_ctrl & bus.HWDATA[CTRL_RST_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_reg <= 1'b0;
    else if (wr_ctrl) en_reg <= bus.HWDATA[CTRL_EN_BIT];
  end

  genvar gi;
  generate
    for (gi = 0; gi < LCD_NUM_WIN; gi++) begin : g_win
      logic [31:0] val_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) val_reg <= '0;
        else if (wr_en && addr_reg == LCD_SC_OFS + 3'(gi)) val_reg <= bus.HWDATA;
      end
      assign win_q[gi] = val_reg;
    end
  endgenerate

  // Pending commands wait out any reset sequence; a set in the firing cycle re-arms
  always_comb begin
    ini_pend_next   = (ini_pend_reg & busy)   | (wr_cmd & bus.HWDATA[CMD_INI_BIT]);
    color_pend_next = (color_pend_reg & busy) | (wr_cmd & bus.HWDATA[CMD_COLOR_BIT]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ini_pend_reg   <= 1'b0;
      color_pend_reg <= 1'b0;
    end else begin
      ini_pend_reg   <= ini_pend_next;
      color_pend_reg <= color_pend_next;
    end
  end

  lcd_rst_seq #(
    .RST_LOW_CYCLES (RST_LOW_CYCLES),
    .RST_WAIT_CYCLES(RST_WAIT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rst_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (seq_start),
    .busy    (busy),
    .lcd_rstn(lcd_rstn)
  );

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr_reg)
        LCD_CTRL_OFS: rdata[CTRL_EN_BIT] = en_reg;
        LCD_SC_OFS:   rdata = win_q[0];
        LCD_EC_OFS:   rdata = win_q[1];
        LCD_SP_OFS:   rdata = win_q[2];
        LCD_EP_OFS:   rdata = win_q[3];
        LCD_STATUS_OFS: begin
          rdata[STAT_BUSY_BIT]  = busy;
          rdata[STAT_INI_BIT]   = ini_pend_reg;
          rdata[STAT_COLOR_BIT] = color_pend_reg;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign en       = en_reg;
  assign ini_en   = ini_pend_reg & ~busy;
  assign color_en = color_pend_reg & ~busy;
  assign set_sc   = win_q[0];
  assign set_ec   = win_q[1];
  assign set_sp   = win_q[2];
  assign set_ep   = win_q[3];

  assign unused_bus_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HSIZE, bus.HTRANS[0]};

endmodule

// File: tb/tb_lcd_ahb_regs.sv
// Randomized self-checking bench for lcd_ahb_regs against a cycle-level
// behavioural model (sequence age counter, register array, pending flags).
module tb_lcd_ahb_regs;

  localparam int LOW = 4;
  localparam int WAIT = 8;
  localparam int SEQ = LOW + WAIT;
  localparam logic [2:0] A_CTRL = 3'd0, A_CMD = 3'd1, A_SC = 3'd2, A_EC = 3'd3,
                         A_SP = 3'd4, A_EP = 3'd5, A_STAT = 3'd6, A_NONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, ini_en, color_en, lcd_rstn;
  logic [31:0] set_sc, set_ec, set_sp, set_ep;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  lcd_ahb_regs_if bus ();

  lcd_ahb_regs #(
    .RST_LOW_CYCLES (LOW),
    .RST_WAIT_CYCLES(WAIT),
    .CNT_W          (24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .en      (en),
    .ini_en  (ini_en),
    .color_en(color_en),
    .set_sc  (set_sc),
    .set_ec  (set_ec),
    .set_sp  (set_sp),
    .set_ep  (set_ep),
    .lcd_rstn(lcd_rstn)
  );

  always #5 clk = ~clk;

  // Behavioural model
  bit          m_en, m_pini, m_pcol;
  logic [31:0] m_win [4];
  int          m_age;
  bit          dp_valid, dp_write;
  logic [2:0]  dp_addr;
  logic [31:0] dp_wdata;

  // Per-cycle observation and expectation
  logic [31:0] obs_rdata, exp_rdata;
  logic        obs_ini, exp_ini, obs_col, exp_col, obs_rstn, exp_rstn, obs_en, exp_en;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_win [4];
  logic [31:0] exp_win [4];

  function automatic bit m_busy();
    return m_age < SEQ;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      A_CTRL: return {31'b0, m_en};
      A_SC, A_EC, A_SP, A_EP: return m_win[a - 3'd2];
      A_STAT: return {29'b0, m_pcol, m_pini, m_busy()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_pini = 0; m_pcol = 0; m_age = 0;
    for (int j = 0; j < 4; j++) m_win[j] = '0;
    dp_valid = 0; dp_write = 0; dp_addr = '0; dp_wdata = '0;
  endtask

  task automatic bus_idle();
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWRITE = 0;
    bus.HSIZE = 3'b010; bus.HWDATA = '0; bus.HREADY = 1;
  endtask

  // One clock: drive a new address phase (or idle) plus data-phase HWDATA,
  // capture outputs and expectations, then advance the model over the edge.
  task automatic step(input bit act, input bit wr, input logic [2:0] a, input logic [31:0] wd);
    bit fi, fc;
    if (act) begin
      bus.HSEL = 1; bus.HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    end else if ($urandom_range(0, 1) != 0) begin
      bus.HSEL = 0; bus.HTRANS = 2'($urandom);
    end else begin
      bus.HSEL = 1; bus.HTRANS = 2'($urandom_range(0, 1));
    end
    bus.HADDR  = {27'($urandom), a, 2'($urandom)};
    bus.HWRITE = act ? wr : 1'($urandom);
    bus.HSIZE  = 3'($urandom);
    bus.HWDATA = (dp_valid && dp_write) ? dp_wdata : $urandom;
    bus.HREADY = 1;
    #1;
    obs_rdata = bus.HRDATA; obs_ini = ini_en; obs_col = color_en; obs_rstn = lcd_rstn;
    obs_en = en; obs_rdy = bus.HREADYOUT; obs_resp = bus.HRESP;
    obs_win[0] = set_sc; obs_win[1] = set_ec; obs_win[2] = set_sp; obs_win[3] = set_ep;
    exp_rdata = (dp_valid && !dp_write) ? m_read(dp_addr) : 32'h0;
    exp_ini = m_pini && !m_busy();
    exp_col = m_pcol && !m_busy();
    exp_rstn = (m_age >= LOW);
    exp_en = m_en;
    for (int j = 0; j < 4; j++) exp_win[j] = m_win[j];
    if (dp_valid)
      $display("[TB] cyc %0d %s addr=0x%02h data=0x%08h", cyc, dp_write ? "WR" : "RD",
               {dp_addr, 2'b00}, dp_write ? dp_wdata : obs_rdata);
    @(posedge clk);
    fi = exp_ini; fc = exp_col;
    if (fi) m_pini = 0;
    if (fc) m_pcol = 0;
    if (m_age < SEQ) m_age++;
    if (dp_valid && dp_write) begin
      case (dp_addr)
        A_CTRL: begin m_en = dp_wdata[0]; if (dp_wdata[1]) m_age = 0; end
        A_CMD:  begin if (dp_wdata[0]) m_pini = 1; if (dp_wdata[1]) m_pcol = 1; end
        A_SC, A_EC, A_SP, A_EP: m_win[dp_addr - 3'd2] = dp_wdata;
        default: ;
      endcase
    end
    dp_valid = act; dp_write = wr; dp_addr = a; dp_wdata = wd;
    cyc++;
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy() || m_pini || m_pcol || dp_valid) && n < budget) begin
      step(0, 0, 3'($urandom), 0);
      n++;
    end
    if (m_busy() || m_pini || m_pcol || dp_valid) begin
      tests++; fails++;
      $display("FAIL wait_idle: budget %0d expired, model age %0d", budget, m_age);
    end
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1; bus_idle();
    repeat (2) @(posedge clk);
    #1;
    tests += 5;
    if (lcd_rstn !== 1'b0) begin fails++; $display("FAIL reset_rstn: got %b want 0", lcd_rstn); end
    if ({en, ini_en, color_en} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b want 000", {en, ini_en, color_en}); end
    if ({set_sc, set_ec, set_sp, set_ep} !== 128'h0) begin fails++; $display("FAIL reset_win: got %h want 0", {set_sc, set_ec, set_sp, set_ep}); end
    if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin fails++; $display("FAIL reset_resp: got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
    model_reset();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, A_STAT, 0);
      if (!obs_rstn) lows++;
      tests += 2;
      if (obs_rstn !== exp_rstn) begin fails++; $display("FAIL seq_rstn cyc %0d: got %b want %b", i, obs_rstn, exp_rstn); end
      if (i >= 1 && obs_rdata !== ((i < SEQ) ? 32'h1 : 32'h0)) begin
        fails++; $display("FAIL seq_status cyc %0d: got %h want %h", i, obs_rdata, (i < SEQ) ? 32'h1 : 32'h0);
      end
    end
    tests++;
    if (lows != LOW) begin fails++; $display("FAIL seq_low_len: got %0d want %0d", lows, LOW); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_window();
    logic [2:0]  adr [4];
    logic [31:0] val [4];
    adr[0] = A_SC; adr[1] = A_EC; adr[2] = A_SP; adr[3] = A_EP;
    val[0] = 32'h10; val[1] = 32'hEF; val[2] = 32'h20; val[3] = 32'h13F;
    for (int k = 0; k < 10; k++) begin
      if (k < 4)      step(1, 1, adr[k], val[k]);
      else if (k < 8) step(1, 0, adr[k - 4], 0);
      else            step(0, 0, 0, 0);
      tests++;
      if (obs_rdy !== 1'b1 || obs_resp !== 1'b0) begin fails++; $display("FAIL win_hready k=%0d: got %b%b want 10", k, obs_rdy, obs_resp); end
      if (k >= 5 && k <= 8) begin
        tests++;
        if (obs_rdata !== val[k - 5]) begin fails++; $display("FAIL win_read %0d: got %h want %h", k - 5, obs_rdata, val[k - 5]); end
      end
    end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (obs_win[j] !== val[j]) begin fails++; $display("FAIL win_out %0d: got %h want %h", j, obs_win[j], val[j]); end
    end
  endtask

  task automatic test_cmd();
    int ni = 0, nc = 0, fi = -1, fcy = -1;
    wait_idle(100);
    step(1, 1, A_CMD, 32'h3);
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 0, A_STAT, 0);
      if (obs_ini) begin ni++; if (fi < 0) fi = i; end
      if (obs_col) begin nc++; if (fcy < 0) fcy = i; end
    end
    tests += 3;
    if (ni != 1 || nc != 1) begin fails++; $display("FAIL cmd_count: got %0d/%0d want 1/1", ni, nc); end
    if (fi != 1 || fcy != 1) begin fails++; $display("FAIL cmd_latency: got %0d/%0d want 1/1", fi, fcy); end
    if (obs_rdata !== 32'h0) begin fails++; $display("FAIL cmd_status: got %h want 0", obs_rdata); end
    // Second CMD write lands in the strobe cycle of the first: two strobes
    ni = 0;
    step(1, 1, A_CMD, 32'h1);
    step(1, 1, A_CMD, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      tests++;
      if (obs_ini !== ((i < 2) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL cmd_rearm %0d: got %b want %b", i, obs_ini, i < 2); end
      if (obs_ini) ni++;
    end
    tests++;
    if (ni != 2) begin fails++; $display("FAIL cmd_rearm_count: got %0d want 2", ni); end
  endtask

  task automatic test_cmd_in_wait();
    int ni = 0;
    step(1, 1, A_CTRL, 32'h2);
    for (int i = 0; i < LOW + 1; i++) step(0, 0, 0, 0);
    step(1, 1, A_CMD, 32'h1);
    step(1, 0, A_STAT, 0);
    step(0, 0, 0, 0);
    tests++;
    if (obs_rdata !== 32'h3) begin fails++; $display("FAIL wait_status: got %h want 3", obs_rdata); end
    for (int i = 0; i < SEQ + 4; i++) begin
      step(0, 0, 0, 0);
      if (obs_ini) ni++;
      tests++;
      if (obs_ini !== exp_ini) begin fails++; $display("FAIL wait_ini cyc %0d: got %b want %b", i, obs_ini, exp_ini); end
    end
    tests++;
    if (ni != 1) begin fails++; $display("FAIL wait_ini_count: got %0d want 1", ni); end
  endtask

  task automatic test_restart();
    int lows = 0, nc = 0, at = -1;
    step(1, 1, A_CTRL, 32'h1);
    step(1, 1, A_CTRL, 32'h3);
    for (int i = 0; i < LOW + 3; i++) step(0, 0, 0, 0);
    step(1, 1, A_CMD, 32'h2);
    step(1, 1, A_CTRL, 32'h2);
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 0, 0);
      if (i >= 1 && !obs_rstn) lows++;
      if (obs_col) begin nc++; if (at < 0) at = i; end
      if (i == 1) begin
        tests += 2;
        if (obs_rstn !== 1'b0) begin fails++; $display("FAIL restart_drop: got %b want 0", obs_rstn); end
        if (obs_en !== 1'b0) begin fails++; $display("FAIL restart_en: got %b want 0", obs_en); end
      end
    end
    tests += 2;
    if (lows != LOW) begin fails++; $display("FAIL restart_low_len: got %0d want %0d", lows, LOW); end
    if (nc != 1 || at != 1 + SEQ) begin fails++; $display("FAIL restart_color: got %0d@%0d want 1@%0d", nc, at, 1 + SEQ); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  a;
    logic [31:0] d;
    step(1, 1, A_CTRL, 32'h1);
    step(1, 0, A_CTRL, 0);
    step(0, 0, 0, 0);
    tests += 2;
    if (obs_rdata !== 32'h1) begin fails++; $display("FAIL ctrl_read: got %h want 1", obs_rdata); end
    if (obs_en !== 1'b1) begin fails++; $display("FAIL ctrl_en: got %b want 1", obs_en); end
    step(1, 1, A_NONE, 32'hDEAD);
    step(1, 0, A_NONE, 0);
    step(0, 0, 0, 0);
    tests++;
    if (obs_rdata !== 32'h0 || obs_resp !== 1'b0) begin fails++; $display("FAIL unmapped: got %h/%b want 0/0", obs_rdata, obs_resp); end
    for (int i = 0; i < 12; i++) begin
      a = 3'($urandom_range(2, 5));
      d = $urandom;
      step(1, 1, a, d);
      step(1, 0, a, 0);
      step(0, 0, 0, 0);
      tests++;
      if (obs_rdata !== d) begin fails++; $display("FAIL b2b addr %0d: got %h want %h", a, obs_rdata, d); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    bit          act;
    for (int i = 0; i < 300; i++) begin
      act = ($urandom_range(0, 9) < 7);
      a = 3'($urandom);
      d = $urandom;
      if (a == A_CTRL) d[1] = ($urandom_range(0, 15) == 0);
      step(act, 1'($urandom), a, d);
      tests += 6;
      if (obs_rdata !== exp_rdata) begin fails++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, obs_rdata, exp_rdata); end
      if (obs_ini !== exp_ini) begin fails++; $display("FAIL rand_ini cyc %0d: got %b want %b", cyc, obs_ini, exp_ini); end
      if (obs_col !== exp_col) begin fails++; $display("FAIL rand_color cyc %0d: got %b want %b", cyc, obs_col, exp_col); end
      if (obs_rstn !== exp_rstn) begin fails++; $display("FAIL rand_rstn cyc %0d: got %b want %b", cyc, obs_rstn, exp_rstn); end
      if (obs_en !== exp_en) begin fails++; $display("FAIL rand_en cyc %0d: got %b want %b", cyc, obs_en, exp_en); end
      if (obs_rdy !== 1'b1 || obs_resp !== 1'b0) begin fails++; $display("FAIL rand_resp cyc %0d: got %b%b want 10", cyc, obs_rdy, obs_resp); end
      for (int j = 0; j < 4; j++) begin
        tests++;
        if (obs_win[j] !== exp_win[j]) begin fails++; $display("FAIL rand_win%0d cyc %0d: got %h want %h", j, cyc, obs_win[j], exp_win[j]); end
      end
    end
  endtask

  task automatic test_rst_mid_read();
    step(1, 1, A_SC, 32'h55);
    step(1, 0, A_SC, 0);
    step(1, 1, A_CTRL, 32'h1);
    #2;
    rst = 1;
    #1;
    tests += 5;
    if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL rstmid_hrdata: got %h want 0", bus.HRDATA); end
    if (set_sc !== 32'h0) begin fails++; $display("FAIL rstmid_sc: got %h want 0", set_sc); end
    if ({en, ini_en, color_en} !== 3'b000) begin fails++; $display("FAIL rstmid_strobes: got %b want 000", {en, ini_en, color_en}); end
    if (lcd_rstn !== 1'b0) begin fails++; $display("FAIL rstmid_rstn: got %b want 0", lcd_rstn); end
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin fails++; $display("FAIL rstmid_resp: got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
    bus_idle();
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      tests++;
      if (obs_en !== 1'b0 || obs_rstn !== 1'b0) begin fails++; $display("FAIL rstmid_after %0d: got %b%b want 00", i, obs_en, obs_rstn); end
    end
  endtask

  initial begin
    bus_idle();
    model_reset();
    test_reset();
    test_window();
    test_cmd();
    test_cmd_in_wait();
    test_restart();
    test_back_to_back();
    test_random();
    test_rst_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
